// File: rtl/keyevent_decoder_pkg.sv
// Shared constants for the PS/2 key-event decoder: prefix bytes, FSM states and default lock scancodes.
package keyevent_pkg;
  localparam logic [7:0] SC_EXT    = 8'hE0;
  localparam logic [7:0] SC_BRK    = 8'hF0;
  localparam logic [7:0] SC_CAPS   = 8'h58;
  localparam logic [7:0] SC_NUM    = 8'h77;
  localparam logic [7:0] SC_SCROLL = 8'h7E;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_EXT    = 2'd1,
    ST_BRK    = 2'd2,
    ST_EXTBRK = 2'd3
  } state_t;

  function automatic logic is_prefix(input logic [7:0] b);
    return (b == SC_EXT) || (b == SC_BRK);
  endfunction
endpackage

// File: rtl/keyevent_decoder_lock_tracker.sv
// One lock toggle with typematic-repeat suppression; the held bit blocks re-toggling until the key is released.
module lock_tracker #(
  parameter logic [7:0] CODE = 8'h58,
  parameter logic       INIT = 1'b0
) (
  input  logic       clk,
  input  logic       i_rst_n,
  input  logic       i_evt,
  input  logic [7:0] i_code,
  input  logic       i_brk,
  input  logic       i_ext,
  output logic       o_lock
);
  logic r_held, r_lock;
  logic w_hit;

  assign w_hit  = i_evt && !i_ext && (i_code == CODE);
  assign o_lock = r_lock;

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_held <= 1'b0;
      r_lock <= INIT;
    end else if (w_hit) begin
      if (i_brk) begin
        r_held <= 1'b0;
      end else if (!r_held) begin
        r_held <= 1'b1;
        r_lock <= ~r_lock;
      end
    end
  end
endmodule

// File: rtl/keyevent_decoder.sv
// Scancode byte stream -> key events (code, break, extended) plus NLOCK lock toggles.
// Optional prefix timeout: define KEYEVENT_DECODER_TIMEOUT_EN.
module keyevent_decoder
  import keyevent_pkg::*;
#(
  parameter int                 NLOCK          = 3,
  parameter logic [NLOCK*8-1:0] LOCK_CODES     = {SC_SCROLL, SC_NUM, SC_CAPS},
  parameter logic [NLOCK-1:0]   LOCK_INIT      = '0,
  parameter int                 TIMEOUT_CYCLES = 1_000_000
) (
  input  logic             clk,
  input  logic             i_rst_n,
  input  logic             i_byte_en,
  input  logic [7:0]       i_byte,
  output logic             o_valid,
  output logic [7:0]       o_byte,
  output logic             o_break,
  output logic             o_ext,
  output logic [NLOCK-1:0] o_locks
);
  state_t     r_state, w_state_nxt, w_state_eff;
  logic       w_emit, w_brk, w_ext, w_timeout;
  logic       r_valid, r_brk, r_ext;
  logic [7:0] r_byte;

`ifdef KEYEVENT_DECODER_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] r_to_cnt;

  assign w_timeout = (r_state != ST_IDLE) && (r_to_cnt == CW'(TIMEOUT_CYCLES));

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n)                    r_to_cnt <= '0;
    else if (i_byte_en || w_timeout) r_to_cnt <= '0;
    else if (r_state != ST_IDLE)     r_to_cnt <= r_to_cnt + 1'b1;
  end
`else
  // Prefix never expires.
  assign w_timeout = (TIMEOUT_CYCLES < 0);
`endif

  // An expiring prefix is dropped in the same cycle, so a coincident byte decodes from IDLE.
  assign w_state_eff = w_timeout ? ST_IDLE : r_state;

  always_comb begin
    w_state_nxt = w_state_eff;
    w_emit      = 1'b0;
    w_brk       = 1'b0;
    w_ext       = 1'b0;
    if (i_byte_en) begin
      unique case (w_state_eff)
        ST_IDLE: begin
          if (i_byte == SC_EXT)      w_state_nxt = ST_EXT;
          else if (i_byte == SC_BRK) w_state_nxt = ST_BRK;
          else                       w_emit = 1'b1;
        end
        ST_EXT: begin
          if (i_byte == SC_BRK)      w_state_nxt = ST_EXTBRK;
          else if (i_byte != SC_EXT) begin
            w_emit = 1'b1; w_ext = 1'b1; w_state_nxt = ST_IDLE;
          end
        end
        ST_BRK: begin
          if (!is_prefix(i_byte)) begin
            w_emit = 1'b1; w_brk = 1'b1; w_state_nxt = ST_IDLE;
          end
        end
        ST_EXTBRK: begin
          if (!is_prefix(i_byte)) begin
            w_emit = 1'b1; w_brk = 1'b1; w_ext = 1'b1; w_state_nxt = ST_IDLE;
          end
        end
        default: w_state_nxt = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= ST_IDLE;
      r_valid <= 1'b0;
      r_byte  <= 8'h00;
      r_brk   <= 1'b0;
      r_ext   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_valid <= w_emit;
      if (w_emit) begin
        r_byte <= i_byte;
        r_brk  <= w_brk;
        r_ext  <= w_ext;
      end
    end
  end

  assign o_valid = r_valid;
  assign o_byte  = r_byte;
  assign o_break = r_brk;
  assign o_ext   = r_ext;

  for (genvar k = 0; k < NLOCK; k++) begin : g_lock
    lock_tracker #(
      .CODE (LOCK_CODES[8*k +: 8]),
      .INIT (LOCK_INIT[k])
    ) u_lock (
      .clk     (clk),
      .i_rst_n (i_rst_n),
      .i_evt   (w_emit),
      .i_code  (i_byte),
      .i_brk   (w_brk),
      .i_ext   (w_ext),
      .o_lock  (o_locks[k])
    );
  end
endmodule

// File: tb/tb_keyevent_decoder.sv
// Self-checking bench: directed literal sequences plus randomized byte stream against a prefix-flag model.
module tb_keyevent_decoder;
  localparam int TO = 10;

  logic       clk = 1'b0;
  logic       i_rst_n = 1'b0;
  logic       i_byte_en = 1'b0;
  logic [7:0] i_byte = 8'h00;
  logic       o_valid, o_break, o_ext;
  logic [7:0] o_byte;
  logic [2:0] o_locks;

  int checks = 0;
  int errors = 0;

  keyevent_decoder #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .i_rst_n(i_rst_n), .i_byte_en(i_byte_en), .i_byte(i_byte),
    .o_valid(o_valid), .o_byte(o_byte), .o_break(o_break), .o_ext(o_ext), .o_locks(o_locks)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %h want %h", name, got, want);
    end
  endtask

  // Model: pending prefixes as two flags; lock state kept per lock code.
  logic [7:0] codes [3] = '{8'h58, 8'h77, 8'h7E};
  logic       m_pe, m_pb, m_valid, m_bk, m_ex;
  logic [7:0] m_byte;
  logic [2:0] m_locks, m_held;
  int         m_idle;
  bit         cmp_en = 1'b0;

  always @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      m_pe <= 0; m_pb <= 0; m_valid <= 0; m_bk <= 0; m_ex <= 0;
      m_byte <= 8'h00; m_locks <= 3'b000; m_held <= 3'b000; m_idle <= 0;
    end else begin
      automatic logic pe = m_pe, pb = m_pb;
      automatic logic [2:0] nl = m_locks, nh = m_held;
      automatic int ni = m_idle;
      m_valid <= 1'b0;
`ifdef KEYEVENT_DECODER_TIMEOUT_EN
      if ((pe || pb) && ni == TO) begin pe = 0; pb = 0; ni = 0; end
`endif
      if (i_byte_en) begin
        ni = 0;
        if (i_byte == 8'hF0) pb = 1;
        else if (i_byte == 8'hE0) begin if (!pb) pe = 1; end
        else begin
          m_valid <= 1'b1; m_byte <= i_byte; m_bk <= pb; m_ex <= pe;
          for (int k = 0; k < 3; k++)
            if (!pe && i_byte == codes[k]) begin
              if (pb) nh[k] = 0;
              else if (!nh[k]) begin nh[k] = 1; nl[k] = ~nl[k]; end
            end
          pe = 0; pb = 0;
        end
      end else if (pe || pb) ni++;
      m_pe <= pe; m_pb <= pb; m_locks <= nl; m_held <= nh; m_idle <= ni;
    end
  end

  always @(negedge clk) begin
    if (cmp_en && i_rst_n) begin
      chk("m_valid", {31'd0, o_valid}, {31'd0, m_valid});
      chk("m_event", {21'd0, o_byte, o_break, o_ext, o_locks}, {21'd0, m_byte, m_bk, m_ex, m_locks});
    end
  end

  // Drive one byte for one cycle; returns on the negedge where its event (if any) is visible.
  task automatic send(input logic [7:0] b);
    i_byte_en = 1'b1; i_byte = b;
    @(negedge clk);
    i_byte_en = 1'b0; i_byte = $urandom_range(255);
  endtask

  task automatic send_ev(input string name, input logic [7:0] b, input logic v,
                         input logic [7:0] eb, input logic bk, input logic ex, input logic [2:0] lk);
    send(b);
    chk({name, "_valid"}, {31'd0, o_valid}, {31'd0, v});
    if (v) chk({name, "_ev"}, {20'd0, o_byte, o_break, o_ext}, {20'd0, eb, bk, ex});
    chk({name, "_locks"}, {29'd0, o_locks}, {29'd0, lk});
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_out", {20'd0, o_valid, o_byte, o_break, o_ext, o_locks},
        {20'd0, 1'b0, 8'h00, 1'b0, 1'b0, 3'b000});
    i_rst_n = 1'b1;
    @(negedge clk);
    cmp_en = 1'b1;

    // Async reset while an E0 prefix is pending, after an event has been emitted.
    send_ev("pre", 8'h58, 1, 8'h58, 0, 0, 3'b001);
    send(8'hE0);
    #2 i_rst_n = 1'b0;
    #1 chk("async_rst", {20'd0, o_valid, o_byte, o_break, o_ext, o_locks},
           {20'd0, 1'b0, 8'h00, 1'b0, 1'b0, 3'b000});
    @(negedge clk); i_rst_n = 1'b1;
    @(negedge clk);
    send_ev("post_rst", 8'h1C, 1, 8'h1C, 0, 0, 3'b000);

    send_ev("mk",   8'h1C, 1, 8'h1C, 0, 0, 3'b000);
    send_ev("f0",   8'hF0, 0, 8'h00, 0, 0, 3'b000);
    send_ev("brk",  8'h1C, 1, 8'h1C, 1, 0, 3'b000);
    @(negedge clk);
    chk("one_cycle", {31'd0, o_valid}, 32'd0);

    send(8'hE0);
    send_ev("xmk",  8'h75, 1, 8'h75, 0, 1, 3'b000);
    send(8'hE0); send(8'hF0);
    send_ev("xbrk", 8'h75, 1, 8'h75, 1, 1, 3'b000);
    send(8'hE0); send(8'hF0); send(8'hF0);
    send_ev("xbrk2", 8'h75, 1, 8'h75, 1, 1, 3'b000);
    send_ev("e1",   8'hE1, 1, 8'hE1, 0, 0, 3'b000);

    send_ev("caps1", 8'h58, 1, 8'h58, 0, 0, 3'b001);
    send_ev("caps2", 8'h58, 1, 8'h58, 0, 0, 3'b001);
    send_ev("caps3", 8'h58, 1, 8'h58, 0, 0, 3'b001);
    send(8'hF0);
    send_ev("capsb", 8'h58, 1, 8'h58, 1, 0, 3'b001);
    send_ev("caps4", 8'h58, 1, 8'h58, 0, 0, 3'b000);
    send(8'hE0);
    send_ev("xcaps", 8'h58, 1, 8'h58, 0, 1, 3'b000);

    send_ev("num",    8'h77, 1, 8'h77, 0, 0, 3'b010);
    send_ev("scroll", 8'h7E, 1, 8'h7E, 0, 0, 3'b110);

    // Back-to-back: strobe held high across consecutive bytes.
    i_byte_en = 1'b1; i_byte = 8'h2A;
    @(negedge clk); i_byte = 8'h3B;
    chk("b2b_1", {23'd0, o_valid, o_byte}, {23'd0, 1'b1, 8'h2A});
    @(negedge clk); i_byte_en = 1'b0;
    chk("b2b_2", {23'd0, o_valid, o_byte}, {23'd0, 1'b1, 8'h3B});

`ifdef KEYEVENT_DECODER_TIMEOUT_EN
    send(8'hF0); repeat (TO) @(negedge clk);
    send_ev("to_exp",  8'h1C, 1, 8'h1C, 0, 0, 3'b110);
    send(8'hF0); repeat (TO - 1) @(negedge clk);
    send_ev("to_hold", 8'h1C, 1, 8'h1C, 1, 0, 3'b110);
`endif

    // Randomized stream, checked every cycle by the compare process.
    for (int n = 0; n < 3000; n++) begin
      automatic int r = $urandom_range(9);
      i_byte_en = ($urandom_range(99) < 60);
      case (r)
        0, 1:    i_byte = 8'hF0;
        2:       i_byte = 8'hE0;
        3:       i_byte = 8'h58;
        4:       i_byte = 8'h77;
        5:       i_byte = 8'h7E;
        6:       i_byte = 8'hE1;
        default: i_byte = $urandom_range(255);
      endcase
`ifdef KEYEVENT_DECODER_TIMEOUT_EN
      if ($urandom_range(99) < 3) begin i_byte_en = 1'b0; repeat ($urandom_range(TO + 2, TO - 1)) @(negedge clk); end
`endif
      @(negedge clk);
    end
    i_byte_en = 1'b0;
    @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
